conv_window_engine: RTL and testbench
=====================================

# conv_window_engine

Parametrised streaming convolution engine for the NPU datapath. It accepts one K_H-pixel image column per handshake and keeps a sliding K_H×K_W window. For every full window it computes NUM_CH output channels from an internal weight bank, applies optional ReLU, right-shift requantisation and saturation, and emits one byte per channel over a valid/ready port. It generalises the fixed 3×3 conv path to arbitrary kernel size, channel count and row width, and adds output mode control and backpressure.

## Interface
- K_H, 3: kernel rows; pixels per input column.
- K_W, 3: kernel columns; window depth.
- NUM_CH, 10: output channels; weight bank holds NUM_CH·K_H·K_W bytes.
- IMG_W, 15: input columns per row.
- ACC_W, 24: accumulator width; must be ≥ 17+clog2(K_H·K_W).
- clk  in  1  clock; one clock domain, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_relu  in  1  1: ReLU plus unsigned clamp; 0: signed clamp.
- cfg_shift  in  5  arithmetic right shift applied before clamp.
- w_we  in  1  weight write strobe.
- w_addr  in  clog2(NUM_CH·K_H·K_W)  weight address = ch·K_H·K_W + col·K_H + row.
- w_data  in  8  signed weight.
- row_start  in  1  restart the column count for a new row.
- in_valid / in_ready  in/out  1  column handshake.
- in_col  in  8·K_H  unsigned pixels; byte r is row r.
- out_valid / out_ready  out/in  1  result handshake.
- out_data  out  8  requantised result.
- out_ch  out  clog2(NUM_CH)  channel of out_data.
- out_col  out  clog2(IMG_W)  output column index in the row (0..IMG_W-K_W).
- out_last  out  1  last channel of last output column of the row.
- busy  out  1  state ≠ IDLE.

## Operation
- FSM has three states.
  - IDLE: in_ready=1.
  - MAC: K_W cycles; column j of the window is used in cycle j.
  - OUT: out_valid=1.
- IDLE, beat accepted: the window shifts; win[K_W-1] ← in_col and win[0] is the oldest column. col_cnt increments.
  - If col_cnt after the increment ≥ K_W, go to MAC with ch=0.
  - If col_cnt after the increment = IMG_W, col_cnt wraps to 0 after this window is processed.
- MAC: acc clears at entry. Each cycle adds Σ_r zext9(win[j][r])·w[ch][j][r]. Products are 17-bit signed and sign-extended to ACC_W.
- MAC→OUT computes out_data in this order:
  - If cfg_relu=1 and acc<0, acc is set to 0.
  - acc >>> cfg_shift.
  - Clamp to [0,255] when relu=1, or to [-128,127] (two's complement) when relu=0.
  - cfg_relu and cfg_shift are sampled at the window-completing beat.
- OUT: the result holds until out_ready=1. On the handshake:
  - If ch<NUM_CH-1: ch++ and go to MAC.
  - Otherwise go to IDLE.
- out_col = col_cnt-K_W (pre-wrap value). out_last=1 only when ch=NUM_CH-1 and col_cnt=IMG_W.
- row_start is honoured only in IDLE and sets col_cnt←0. The window contents are not cleared and become stale.
  - With row_start and in_valid in the same cycle, the clear happens first and the beat counts as column 1.
- Weight writes take effect only in IDLE and are ignored in MAC/OUT.
- Columns that arrive while not in IDLE are not accepted (in_ready=0). The source must hold them.

## Timing
- Reset values:
  - State IDLE, col_cnt=0, ch=0, acc=0.
  - Window and weight bank all 0.
  - out_valid=0, out_data=0, out_ch=0, out_col=0, out_last=0.
  - busy=0, in_ready=1 in the cycle after rst deasserts.
- Window-completing beat accepted at cycle t:
  - MAC runs in cycles t+1..t+K_W.
  - out_valid=1 from t+K_W+1.
- Handshake at cycle u for ch<NUM_CH-1: out_valid=0 in cycles u+1..u+K_W; the next channel is valid at u+K_W+1.
- Handshake on the last channel at u: in_ready=1 at u+1.
- Per-window throughput with out_ready=1 is NUM_CH·(K_W+1)+1 cycles.
- out_data, out_ch, out_col and out_last are stable while out_valid=1 and out_ready=0.
- rst in any state returns everything to reset values on the next edge. Any in-flight result is discarded.

## Test plan
- Reset and zero weights (K=3, NUM_CH=2, IMG_W=5): pulse rst and feed 3 columns of 10s → two results, both 0; in_ready low for 2·4 cycles.
- Basic MAC: ch0 weights all +1, ch1 all −1, pixels 10, relu=1, shift=0 → ch0=90, ch1=0. With relu=0 → ch1=0xA6 (−90). out_valid rises exactly 4 cycles after the third beat.
- Saturation/shift: pixels 255, weights 127 (acc=291465), relu=1:
  - shift 0 → 255.
  - shift 12 → 71.
  - relu=0, shift 12 → 71.
  - relu=0, shift 0 → 127.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 → outputs are frozen, no column is accepted and col_cnt is unchanged.
- Row wrap: feed 6 columns →
  - Outputs for out_col 0,1,2.
  - out_last only on ch1 of col 2.
  - The 6th column starts a new row and produces no output.
  - row_start mid-row likewise delays output until 3 new columns have arrived.
- Mid-operation reset and weight lockout: w_we during OUT does not change weights. rst during MAC → next cycle IDLE, out_valid=0, all weights read back as zero results.

Source files
------------

// File: rtl/conv_window_engine.sv
`default_nettype none
// ----------------------------------------------------------------------------
// conv_window_engine : streaming K_H x K_W sliding-window convolution with
//                      per-channel ReLU / shift / saturation requantisation.
// Revision 1.0
// ----------------------------------------------------------------------------
module conv_window_engine #(
  parameter  int K_H    = 3,
  parameter  int K_W    = 3,
  parameter  int NUM_CH = 10,
  parameter  int IMG_W  = 15,
  parameter  int ACC_W  = 24,
  localparam int NW     = NUM_CH * K_H * K_W,
  localparam int AW     = (NW > 1) ? $clog2(NW) : 1,
  localparam int CHW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int OCW    = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_relu,
  input  logic [4:0]       cfg_shift,
  input  logic             w_we,
  input  logic [AW-1:0]    w_addr,
  input  logic [7:0]       w_data,
  input  logic             row_start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [8*K_H-1:0] in_col,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic [CHW-1:0]   out_ch,
  output logic [OCW-1:0]   out_col,
  output logic             out_last,
  output logic             busy
);

  localparam int CNTW = $clog2(IMG_W + 1);
  localparam int JW   = (K_W > 1) ? $clog2(K_W) : 1;
  localparam int KK   = K_H * K_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  logic [1:0]              r_state;
  logic [8*K_H-1:0]        r_win [K_W];
  logic signed [7:0]       r_wgt [NW];
  logic [CNTW-1:0]         r_col_cnt;
  logic [CHW-1:0]          r_ch;
  logic [JW-1:0]           r_j;
  logic signed [ACC_W-1:0] r_acc;
  logic                    r_relu;
  logic [4:0]              r_shift;
  logic [7:0]              r_out_data;
  logic [CHW-1:0]          r_out_ch;
  logic [OCW-1:0]          r_out_col;
  logic                    r_out_last;

  logic [CNTW-1:0]         w_cnt_inc;
  logic                    w_win_full;
  logic [AW-1:0]           w_base;
  logic [7:0]              w_pix;
  logic signed [16:0]      w_prod;
  logic signed [ACC_W-1:0] w_sum;
  logic signed [ACC_W-1:0] w_acc_next;
  logic signed [ACC_W-1:0] w_pos;
  logic signed [ACC_W-1:0] w_shd;
  logic [7:0]              w_q;
  logic                    w_last_ch;

  // A row_start arriving with a beat clears first, so the beat is column 1.
  assign w_cnt_inc  = (row_start ? '0 : r_col_cnt) + CNTW'(1);
  assign w_win_full = (int'(w_cnt_inc) >= K_W);
  assign w_base     = AW'(int'(r_ch) * KK + int'(r_j) * K_H);
  assign w_last_ch  = (int'(r_ch) == NUM_CH - 1);

  // One window column per MAC cycle: K_H unsigned-pixel x signed-weight taps.
  always_comb begin
    w_sum  = '0;
    w_pix  = '0;
    w_prod = '0;
    for (int r = 0; r < K_H; r++) begin
      w_pix  = r_win[r_j][8*r +: 8];
      w_prod = $signed({1'b0, w_pix}) * r_wgt[w_base + AW'(r)];
      w_sum  = w_sum + ACC_W'(w_prod);
    end
  end

  assign w_acc_next = r_acc + w_sum;

  always_comb begin
    w_pos = (r_relu && w_acc_next[ACC_W-1]) ? '0 : w_acc_next;
    w_shd = w_pos >>> r_shift;
    if (r_relu) begin
      w_q = (w_shd > 255) ? 8'hFF : w_shd[7:0];
    end else if (w_shd > 127) begin
      w_q = 8'h7F;
    end else if (w_shd < -128) begin
      w_q = 8'h80;
    end else begin
      w_q = w_shd[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_col_cnt  <= '0;
      r_ch       <= '0;
      r_j        <= '0;
      r_acc      <= '0;
      r_relu     <= 1'b0;
      r_shift    <= '0;
      r_out_data <= '0;
      r_out_ch   <= '0;
      r_out_col  <= '0;
      r_out_last <= 1'b0;
      for (int k = 0; k < K_W; k++) r_win[k] <= '0;
      for (int k = 0; k < NW; k++)  r_wgt[k] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_we && (int'(w_addr) < NW)) r_wgt[w_addr] <= w_data;
          if (in_valid) begin
            for (int k = 0; k < K_W - 1; k++) r_win[k] <= r_win[k+1];
            r_win[K_W-1] <= in_col;
            r_col_cnt    <= w_cnt_inc;
            if (w_win_full) begin
              r_state <= S_MAC;
              r_ch    <= '0;
              r_j     <= '0;
              r_acc   <= '0;
              r_relu  <= cfg_relu;
              r_shift <= cfg_shift;
            end
          end else if (row_start) begin
            r_col_cnt <= '0;
          end
        end
        S_MAC: begin
          r_acc <= w_acc_next;
          if (int'(r_j) == K_W - 1) begin
            r_out_data <= w_q;
            r_out_ch   <= r_ch;
            r_out_col  <= OCW'(r_col_cnt - CNTW'(K_W));
            r_out_last <= w_last_ch && (int'(r_col_cnt) == IMG_W);
            r_state    <= S_OUT;
          end else begin
            r_j <= r_j + JW'(1);
          end
        end
        S_OUT: begin
          if (out_ready) begin
            if (!w_last_ch) begin
              r_ch    <= r_ch + CHW'(1);
              r_j     <= '0;
              r_acc   <= '0;
              r_state <= S_MAC;
            end else begin
              r_state <= S_IDLE;
              if (int'(r_col_cnt) == IMG_W) r_col_cnt <= '0;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_OUT);
  assign busy      = (r_state != S_IDLE);
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
  assign out_col   = r_out_col;
  assign out_last  = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_conv_window_engine.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_conv_window_engine : directed + random stimulus against a window model.
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_conv_window_engine;

  localparam int K_H    = 3;
  localparam int K_W    = 3;
  localparam int NUM_CH = 2;
  localparam int IMG_W  = 5;
  localparam int ACC_W  = 24;
  localparam int KK     = K_H * K_W;
  localparam int AW     = $clog2(NUM_CH * KK);
  localparam int CHW    = 1;
  localparam int OCW    = $clog2(IMG_W);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_relu = 1'b0;
  logic [4:0]       cfg_shift = '0;
  logic             w_we = 1'b0;
  logic [AW-1:0]    w_addr = '0;
  logic [7:0]       w_data = '0;
  logic             row_start = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [8*K_H-1:0] in_col = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [7:0]       out_data;
  logic [CHW-1:0]   out_ch;
  logic [OCW-1:0]   out_col;
  logic             out_last;
  logic             busy;

  conv_window_engine #(
    .K_H(K_H), .K_W(K_W), .NUM_CH(NUM_CH), .IMG_W(IMG_W), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .rst(rst), .cfg_relu(cfg_relu), .cfg_shift(cfg_shift),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .row_start(row_start),
    .in_valid(in_valid), .in_ready(in_ready), .in_col(in_col),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ch(out_ch), .out_col(out_col), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: window as plain integers, weights as [ch][col][row].
  int mwin [K_W][K_H];
  int mwgt [NUM_CH][K_W][K_H];
  int mcnt = 0;
  logic [7:0] got [NUM_CH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < K_W; j++)
      for (int r = 0; r < K_H; r++) begin
        mwin[j][r] = 0;
        for (int c = 0; c < NUM_CH; c++) mwgt[c][j][r] = 0;
      end
    mcnt = 0;
  endtask

  function automatic logic [7:0] ref_out(input int ch, input bit relu, input int sh);
    longint acc = 0;
    for (int j = 0; j < K_W; j++)
      for (int r = 0; r < K_H; r++)
        acc += longint'(mwin[j][r]) * longint'(mwgt[ch][j][r]);
    if (relu && acc < 0) acc = 0;
    acc = acc >>> sh;
    if (relu) begin
      if (acc > 255) acc = 255;
    end else begin
      if (acc > 127) acc = 127;
      if (acc < -128) acc = -128;
    end
    return 8'(acc);
  endfunction

  function automatic logic [8*K_H-1:0] rep(input int p);
    logic [8*K_H-1:0] v;
    for (int r = 0; r < K_H; r++) v[8*r +: 8] = 8'(p);
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; w_we = 1'b0; row_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic write_w(input int ch, input int col, input int row, input int v);
    w_we = 1'b1; w_addr = AW'(ch * KK + col * K_H + row); w_data = 8'(v);
    @(negedge clk);
    w_we = 1'b0;
    mwgt[ch][col][row] = v;
  endtask

  task automatic set_w_all(input int v0, input int v1);
    for (int j = 0; j < K_W; j++)
      for (int r = 0; r < K_H; r++) begin
        write_w(0, j, r, v0);
        write_w(1, j, r, v1);
      end
  endtask

  task automatic set_w_random();
    int v;
    for (int c = 0; c < NUM_CH; c++)
      for (int j = 0; j < K_W; j++)
        for (int r = 0; r < K_H; r++) begin
          v = int'($urandom_range(255, 0)) - 128;
          write_w(c, j, r, v);
        end
  endtask

  // Drains all channels of one window; junk weight writes during MAC/OUT must be ignored.
  task automatic collect(input bit relu, input int sh, input int stall);
    int lat;
    int s;
    logic [7:0] exp;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      lat = 0;
      while (!out_valid && lat < 40) begin
        w_we = 1'b1; w_addr = AW'($urandom); w_data = 8'($urandom);
        @(negedge clk);
        lat++;
      end
      check("latency", lat, K_W);
      s = (stall < 0) ? int'($urandom_range(3, 0)) : stall;
      for (int k = 0; k < s; k++) begin
        in_valid = 1'b1; in_col = ($urandom);
        w_we = 1'b1; w_addr = AW'($urandom); w_data = 8'($urandom);
        @(negedge clk);
      end
      if (s > 0) check("stall_in_ready", in_ready, 0);
      in_valid = 1'b0; w_we = 1'b0;
      exp = ref_out(ch, relu, sh);
      check("out_valid", out_valid, 1);
      check("out_data", out_data, exp);
      check("out_ch", out_ch, ch);
      check("out_col", out_col, mcnt - K_W);
      check("out_last", out_last, (ch == NUM_CH - 1) && (mcnt == IMG_W));
      got[ch] = out_data;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
    check("idle_after_window", in_ready, 1);
  endtask

  task automatic send_col(input logic [8*K_H-1:0] col, input bit rs, input bit relu,
                          input int sh, input int stall);
    check("in_ready_before_beat", in_ready, 1);
    in_valid = 1'b1; in_col = col; row_start = rs; cfg_relu = relu; cfg_shift = 5'(sh);
    @(negedge clk);
    in_valid = 1'b0; row_start = 1'b0;
    cfg_relu = 1'($urandom); cfg_shift = 5'($urandom);
    if (rs) mcnt = 0;
    for (int j = 0; j < K_W - 1; j++)
      for (int r = 0; r < K_H; r++) mwin[j][r] = mwin[j+1][r];
    for (int r = 0; r < K_H; r++) mwin[K_W-1][r] = int'(col[8*r +: 8]);
    mcnt++;
    if (mcnt >= K_W) begin
      collect(relu, sh, stall);
      if (mcnt == IMG_W) mcnt = 0;
    end else begin
      check("no_window_busy", busy, 0);
    end
  endtask

  task automatic window3(input logic [8*K_H-1:0] col, input bit relu, input int sh, input int stall);
    send_col(col, 1'b1, relu, sh, 0);
    send_col(col, 1'b0, relu, sh, 0);
    send_col(col, 1'b0, relu, sh, stall);
  endtask

  initial begin
    // Reset values and zero weights
    do_reset();
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ch", out_ch, 0);
    check("rst_out_col", out_col, 0);
    check("rst_out_last", out_last, 0);
    for (int i = 0; i < 3; i++) send_col(rep(10), 1'b0, 1'b1, 0, 0);
    check("zero_w_ch0", got[0], 0);
    check("zero_w_ch1", got[1], 0);

    // Basic MAC, ReLU on and off
    do_reset();
    set_w_all(1, -1);
    window3(rep(10), 1'b1, 0, 0);
    check("basic_ch0", got[0], 90);
    check("basic_ch1_relu", got[1], 0);
    window3(rep(10), 1'b0, 0, 0);
    check("basic_ch1_signed", got[1], 8'hA6);

    // Saturation and shift
    set_w_all(127, 127);
    window3(rep(255), 1'b1, 0, 0);
    check("sat_relu_s0", got[0], 255);
    window3(rep(255), 1'b1, 12, 0);
    check("sat_relu_s12", got[0], 71);
    window3(rep(255), 1'b0, 12, 0);
    check("sat_signed_s12", got[0], 71);
    window3(rep(255), 1'b0, 0, 0);
    check("sat_signed_s0", got[0], 127);

    // Backpressure with a column held at the input
    set_w_random();
    window3(($urandom), 1'b0, 4, 5);

    // Row wrap, then row_start mid-row (with and without a beat)
    send_col(($urandom), 1'b1, 1'b1, 2, 0);
    for (int i = 0; i < 5; i++) send_col(($urandom), 1'b0, 1'b1, 2, -1);
    send_col(($urandom), 1'b0, 1'b0, 3, 0);
    send_col(($urandom), 1'b1, 1'b0, 3, 0);
    send_col(($urandom), 1'b0, 1'b0, 3, 0);
    row_start = 1'b1;
    @(negedge clk);
    row_start = 1'b0;
    mcnt = 0;
    for (int i = 0; i < 3; i++) send_col(($urandom), 1'b0, 1'b0, 3, 0);

    // Reset during MAC discards the result and clears weights
    set_w_all(5, -7);
    send_col(rep(10), 1'b1, 1'b0, 0, 0);
    send_col(rep(10), 1'b0, 1'b0, 0, 0);
    in_valid = 1'b1; in_col = rep(10);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("mac_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("midrst_busy", busy, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    window3(rep(10), 1'b0, 0, 0);
    check("midrst_ch0", got[0], 0);
    check("midrst_ch1", got[1], 0);

    // Randomised traffic
    set_w_random();
    for (int i = 0; i < 40; i++)
      send_col(($urandom), ($urandom_range(7, 0) == 0), 1'($urandom),
               int'($urandom_range(12, 0)), -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
